bcd_serial_subtractor: RTL and testbench
========================================

Name: bcd_serial_subtractor

Overview:
- Multi-digit packed-BCD subtractor; computes A − B − bin.
- Processes one decimal digit per clock through a single shared digit-subtract cell.
- Returns a sign-magnitude BCD result. Negative results get a second ten's-complement correction pass.
- Companion to the combinational BCD adder; used where area matters more than latency, e.g. counters and accumulator datapaths that must decrement or compute differences.

Parameters:
- DIGITS, 4, number of BCD digits in a, b and diff (≥1); operand width 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0]
- b  input  4*DIGITS  subtrahend, packed BCD
- bin  input  1  borrow-in
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; result valid
- diff  output  4*DIGITS  magnitude of the result, packed BCD
- neg  output  1  1 = result negative (A < B + bin)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n. Sampled at the rising edge, rst_n=0 forces:
  - state=IDLE;
  - busy=0, done=0, diff=0, neg=0;
  - internal operand registers, digit counter and borrow flop cleared.
- Reset mid-operation aborts; no done pulse is produced.
- Digit cell (combinational): d = x − y − br.
  - If d<0: out = d+10, br_next=1.
  - Else: out = d, br_next=0.
  - 4-bit digits; arithmetic done in 5-bit signed.
- FSM states: IDLE, SUB, FIX, DONE.
  - IDLE:
    - start=1 → capture a, b; load the borrow flop with bin; clear the digit counter.
    - Go to SUB; busy=1 from the next cycle.
    - start=0 → stay.
  - SUB:
    - Each cycle, apply the cell to digit k (k = counter, 0..DIGITS−1) of the captured a, b and the borrow flop.
    - Write the output into result digit k; update the borrow flop; k++.
    - After k=DIGITS−1:
      - final borrow=0 → DONE;
      - final borrow=1 → clear the counter and borrow flop, then go to FIX.
  - FIX:
    - Each cycle, result digit k ← cell(0, result digit k, br). This is the ten's complement, 10^DIGITS − raw.
    - After k=DIGITS−1 → DONE.
    - neg is set to 1 on entry to FIX.
  - DONE:
    - done=1, busy=0 for exactly one cycle; diff drives the result register.
    - Next state IDLE. start is ignored in DONE.
- neg is cleared at start acceptance.
- Latency, counting the accept edge as cycle 0:
  - non-negative: done high in cycle DIGITS+1;
  - negative: done high in cycle 2*DIGITS+1.
- diff and neg update while busy (intermediate values) and hold their final values from DONE until the next accepted start.
- start while busy or in DONE is ignored; it is not queued.
- Input changes after acceptance have no effect, because operands are captured at acceptance.
- Boundary conditions:
  - A=B, bin=0 → diff=0, neg=0.
  - A=0, B=0, bin=1 → raw all-9s with borrow → diff=...0001, neg=1.
  - neg is never 1 with diff=0.
- Non-BCD input digits (>9) give a deterministic but unspecified result when the optional feature is compiled out.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- When defined, the block adds output port invalid (1 bit, reset 0). At start acceptance, if any digit of a or b is >9:
  - skip SUB/FIX and go directly to DONE;
  - done is high in cycle 1;
  - diff=0, neg=0, invalid=1.
- invalid holds until the next accepted start and is cleared at acceptance when the inputs are valid.
- When undefined:
  - no invalid port and no check logic;
  - behaviour is as above.

Test Plan (DIGITS=4):
- a=0x5321, b=0x1234, bin=0 → diff=0x4087, neg=0, done pulse in cycle 5, busy high cycles 1–4.
- a=0x1234, b=0x5321, bin=0 → raw 0x5913 after SUB, FIX entered → diff=0x4087, neg=1, done in cycle 9.
- Borrow chain and borrow-in:
  - a=0x1000, b=0x0001, bin=0 → diff=0x0999, neg=0.
  - a=0x0000, b=0x0000, bin=1 → diff=0x0001, neg=1.
  - a=0x9999, b=0x9999 → diff=0x0000, neg=0.
- Handshake and reset:
  - Hold start=1 continuously → one operation per IDLE visit. A start during busy/DONE is not accepted, so the next accept is the cycle after DONE.
  - rst_n=0 in the 2nd SUB cycle → next cycle busy=0, done=0, diff=0, neg=0. A following start completes normally.
- With BCD_DIGIT_CHECK_EN:
  - a=0x12A4, b=0x0001 → done in cycle 1, invalid=1, diff=0, neg=0.
  - A subsequent valid operation clears invalid at acceptance.

Source files
------------

// File: rtl/bcd_serial_subtractor.sv
// -----------------------------------------------------------------------------
// bcd_serial_subtractor
//
// Multi-digit packed-BCD subtractor that computes A - B - bin one decimal digit
// per clock through a single shared digit-subtract cell. The result is in
// sign-magnitude form. When the raw difference borrows out of the top digit, a
// second pass over the result register forms its ten's complement
// (10^DIGITS - raw), which yields the magnitude, and neg is set.
//
// Latency (the accept edge ends cycle 0):
//   non-negative result : done high in cycle DIGITS+1
//   negative result     : done high in cycle 2*DIGITS+1
//
// Parameters:
//   DIGITS   number of BCD digits in a, b and diff (>= 1)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start    request, sampled only while idle
//   a        minuend, packed BCD, digit 0 = bits [3:0]
//   b        subtrahend, packed BCD
//   bin      borrow-in
//   busy     high from the cycle after acceptance until done
//   done     one-cycle pulse, result valid
//   diff     result magnitude, packed BCD
//   neg      1 = result negative (A < B + bin)
//   invalid  (only with BCD_DIGIT_CHECK_EN) an input digit was > 9
//
// Optional feature: define BCD_DIGIT_CHECK_EN to add the invalid output and
// the input digit range check. Invalid operands skip straight to the done
// cycle with diff=0, neg=0, invalid=1.
// -----------------------------------------------------------------------------
module bcd_serial_subtractor #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                  invalid
`endif
);

  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned W  = 4 * DIGITS;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSub  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          neg_q, neg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef BCD_DIGIT_CHECK_EN
  logic          invalid_q, invalid_d;
`endif

  // Digit operands selected by the counter.
  logic [3:0]    dig_a, dig_b, dig_r;
  logic [3:0]    cell_x, cell_y;
  logic [4:0]    cell_raw;
  logic [3:0]    cell_out;
  logic          cell_bout;
  logic          last_digit;
  // Result register with the current digit replaced by the cell output.
  logic [W-1:0]  res_wr;

`ifdef BCD_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction
`endif

  // Digit selection and the shared digit-subtract cell.
  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    dig_r = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cnt_q == CW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
        dig_r = res_q[4*i +: 4];
      end
    end

    // The correction pass subtracts the raw result from zero.
    if (state_q == StFix) begin
      cell_x = 4'd0;
      cell_y = dig_r;
    end else begin
      cell_x = dig_a;
      cell_y = dig_b;
    end

    // 5-bit two's-complement difference; bit 4 set means the digit went below 0.
    cell_raw  = {1'b0, cell_x} - {1'b0, cell_y} - {4'd0, br_q};
    cell_bout = cell_raw[4];
    cell_out  = cell_bout ? (cell_raw[3:0] + 4'd10) : cell_raw[3:0];

    res_wr = res_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cnt_q == CW'(i)) begin
        res_wr[4*i +: 4] = cell_out;
      end
    end

    last_digit = (cnt_q == CW'(DIGITS - 1));
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    br_d      = br_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    invalid_d = invalid_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
          neg_d   = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
          if (has_bad_digit(a) || has_bad_digit(b)) begin
            invalid_d = 1'b1;
            done_d    = 1'b1;
            state_d   = StDone;
          end else begin
            invalid_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = StSub;
          end
`else
          busy_d  = 1'b1;
          state_d = StSub;
`endif
        end
      end

      StSub: begin
        res_d = res_wr;
        br_d  = cell_bout;
        cnt_d = cnt_q + CW'(1);
        if (last_digit) begin
          if (cell_bout) begin
            // Raw result is 10^DIGITS + (A - B - bin); complement it in place.
            cnt_d   = '0;
            br_d    = 1'b0;
            neg_d   = 1'b1;
            state_d = StFix;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end

      StFix: begin
        res_d = res_wr;
        br_d  = cell_bout;
        cnt_d = cnt_q + CW'(1);
        if (last_digit) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        // start is deliberately not looked at here.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      br_q      <= 1'b0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      invalid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      br_q      <= br_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BCD_DIGIT_CHECK_EN
      invalid_q <= invalid_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign diff    = res_q;
  assign neg     = neg_q;
`ifdef BCD_DIGIT_CHECK_EN
  assign invalid = invalid_q;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4).
// An arithmetic model (BCD -> integer, subtract, integer -> BCD) predicts the
// outputs every cycle; directed tests pin latencies and hand-computed results.
module tb_bcd_serial_subtractor;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         neg;
`ifdef BCD_DIGIT_CHECK_EN
  logic         invalid;
`endif

  bcd_serial_subtractor #(
    .DIGITS(D)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .neg    (neg)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .invalid(invalid)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- model
  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic bad_bcd(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] md, output logic mn, output int mlat,
                       output logic minv);
    int r;
    r    = bcd2int(ma) - bcd2int(mb) - (mbin ? 1 : 0);
    mn   = (r < 0);
    md   = int2bcd(mn ? -r : r);
    mlat = mn ? 2 * D + 1 : D + 1;
    minv = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    if (bad_bcd(ma) || bad_bcd(mb)) begin
      md   = '0;
      mn   = 1'b0;
      mlat = 1;
      minv = 1'b1;
    end
`endif
  endtask

  // ----------------------------------------------------- per-cycle compare
  // phase = cycles since the accept edge (0 = idle); lat_m = cycle of done.
  logic         armed = 1'b0;
  int           phase = 0;
  int           lat_m = 0;
  logic [W-1:0] exp_d = '0;
  logic         exp_n = 1'b0;
  logic         exp_i = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", {31'd0, busy}, {31'd0, (phase >= 1 && phase < lat_m)});
      chk("done", {31'd0, done}, {31'd0, (phase != 0 && phase == lat_m)});
      if (phase == 0 || phase == lat_m) begin
        chk("diff", {16'd0, diff}, {16'd0, exp_d});
        chk("neg", {31'd0, neg}, {31'd0, exp_n});
        if (neg === 1'b1) chk("neg_with_zero", {16'd0, diff} == 32'd0, 32'd0);
`ifdef BCD_DIGIT_CHECK_EN
        chk("invalid", {31'd0, invalid}, {31'd0, exp_i});
`endif
      end
    end
    // Predict the cycle after the coming rising edge; inputs are stable here.
    if (!rst_n) begin
      armed = 1'b1;
      phase = 0;
      lat_m = 0;
      exp_d = '0;
      exp_n = 1'b0;
      exp_i = 1'b0;
    end else if (armed) begin
      if (phase == 0) begin
        if (start) begin
          model(a, b, bin, exp_d, exp_n, lat_m, exp_i);
          phase = 1;
        end
      end else if (phase == lat_m) begin
        phase = 0;
      end else begin
        phase++;
      end
    end
  end

  // ------------------------------------------------------------- directed
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vbin, input logic [W-1:0] ed, input logic en,
                        input int elat);
    int cyc;
    @(posedge clk); #1;
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(posedge clk); #1;
    // Operands are captured; scrambling the inputs must not matter.
    start = 1'b0; a = 16'h9876; b = 16'h0123; bin = ~vbin;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done !== 1'b1) chk({name, "_timeout"}, 32'd0, 32'd1);
    chk({name, "_latency"}, cyc, elat);
    chk({name, "_diff"}, {16'd0, diff}, {16'd0, ed});
    chk({name, "_neg"}, {31'd0, neg}, {31'd0, en});
  endtask

  initial begin
    logic [W-1:0] md;
    logic         mn;
    logic         mi;
    int           ml;
    int           n;

    // Pin the model against hand-computed values.
    model(16'h5321, 16'h1234, 1'b0, md, mn, ml, mi);
    chk("model_pos", {15'd0, mn, md}, {15'd0, 1'b0, 16'h4087});
    model(16'h1234, 16'h5321, 1'b0, md, mn, ml, mi);
    chk("model_neg", {15'd0, mn, md}, {15'd0, 1'b1, 16'h4087});
    chk("model_neg_lat", ml, 9);
    model(16'h0000, 16'h0000, 1'b1, md, mn, ml, mi);
    chk("model_bin", {15'd0, mn, md}, {15'd0, 1'b1, 16'h0001});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_neg", {31'd0, neg}, 32'd0);
    rst_n = 1'b1;

    run_op("pos",     16'h5321, 16'h1234, 1'b0, 16'h4087, 1'b0, 5);
    run_op("negfix",  16'h1234, 16'h5321, 1'b0, 16'h4087, 1'b1, 9);
    run_op("chain",   16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 5);
    run_op("zbin",    16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b1, 9);
    run_op("equal",   16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0, 5);
    run_op("minus1",  16'h0005, 16'h0005, 1'b1, 16'h0001, 1'b1, 9);
    run_op("maxbin",  16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 5);
    run_op("negbig",  16'h0000, 16'h9999, 1'b0, 16'h9999, 1'b1, 9);

    // start held high: next accept is the cycle after the done cycle.
    @(posedge clk); #1;
    a = 16'h5321; b = 16'h1234; bin = 1'b0; start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_first_done", {31'd0, done}, 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (done !== 1'b1 && n < 40);
    chk("hold_spacing", n, 6);
    chk("hold_diff", {16'd0, diff}, 32'h4087);
    start = 1'b0;

    // Reset during the second SUB cycle aborts the operation.
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h5321; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_diff", {16'd0, diff}, 32'd0);
    chk("abort_neg", {31'd0, neg}, 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_op("after_rst", 16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 5);

`ifdef BCD_DIGIT_CHECK_EN
    run_op("inv", 16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1);
    chk("inv_flag", {31'd0, invalid}, 32'd1);
    run_op("inv_clear", 16'h0010, 16'h0003, 1'b0, 16'h0007, 1'b0, 5);
    chk("inv_cleared", {31'd0, invalid}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
